// File: rtl/crc_engine.sv
// -----------------------------------------------------------------------------
// crc_engine
//
// Parameterised CRC calculator. Each valid beat advances the CRC register by
// DATA_W serial LFSR shifts in a single clock cycle. The beat flagged as last
// completes the frame. On the following cycle the result appears on axiod,
// together with a one-cycle axiov pulse.
//
// Parameters
//   WIDTH    CRC register width (3..32)
//   DATA_W   data bits consumed per valid beat (1..16)
//   POLY     generator polynomial, normal form, x^WIDTH term implicit
//   INIT     register value loaded at frame start
//   REFIN    1: axiid bit 0 shifted first, 0: bit DATA_W-1 shifted first
//   REFOUT   1: final register bit-reversed before XOROUT
//   XOROUT   value XORed into the final result
//   RESIDUE  raw register value expected after data plus appended CRC
//
// Ports
//   clk     in   sole clock, rising edge
//   rst     in   asynchronous reset, active low
//   axiiv   in   input beat valid
//   axiid   in   input data beat [DATA_W-1:0]
//   axiil   in   last beat of frame (only meaningful with axiiv)
//   clr     in   synchronous abort of the current frame
//   axiov   out  result valid, single-cycle pulse
//   axiod   out  final CRC of the most recent completed frame [WIDTH-1:0]
//   busy    out  frame in progress
//   crc_ok  out  raw register matched RESIDUE at frame end
//                (only when CRC_ENGINE_RESIDUE_CHECK_EN is defined)
//
// Optional feature macro: CRC_ENGINE_RESIDUE_CHECK_EN
// -----------------------------------------------------------------------------
module crc_engine #(
    parameter int               WIDTH   = 8,
    parameter int               DATA_W  = 8,
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] INIT    = '1,
    parameter bit               REFIN   = 1'b1,
    parameter bit               REFOUT  = 1'b1,
    parameter logic [WIDTH-1:0] XOROUT  = '0,
    parameter logic [WIDTH-1:0] RESIDUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [DATA_W-1:0] axiid,
    input  logic              axiil,
    input  logic              clr,
    output logic              axiov,
    output logic [WIDTH-1:0]  axiod,
`ifdef CRC_ENGINE_RESIDUE_CHECK_EN
    output logic              crc_ok,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  crc_reg;
    logic [WIDTH-1:0]  axiod_reg;
    logic              axiov_reg;
    logic              busy_reg;

    // Data bits re-ordered so that index k is the bit shifted in at step k.
    logic [DATA_W-1:0] data_ord;
    // Register value the current beat starts from: a frame in progress
    // continues, otherwise (IDLE or DONE) a new frame begins from INIT.
    logic [WIDTH-1:0]  seed;
    logic [WIDTH-1:0]  crc_next;
    logic [WIDTH-1:0]  crc_next_rev;
    logic [WIDTH-1:0]  result_next;
    logic              fb;

    genvar gi;

    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_order
            if (REFIN) begin : g_lsb_first
                assign data_ord[gi] = axiid[gi];
            end else begin : g_msb_first
                assign data_ord[gi] = axiid[DATA_W-1-gi];
            end
        end
    endgenerate

    assign seed = (state_reg == CALC) ? crc_reg : INIT;

    // DATA_W serial shifts of a Galois LFSR, unrolled into one cycle.
    always_comb begin
        crc_next = seed;
        fb       = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            fb       = crc_next[WIDTH-1] ^ data_ord[i];
            crc_next = {crc_next[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_reverse
            assign crc_next_rev[gi] = crc_next[WIDTH-1-gi];
        end
    endgenerate

    assign result_next = (REFOUT ? crc_next_rev : crc_next) ^ XOROUT;

    // The output result is computed from the register value as it is being
    // written. So axiod is already valid when the DONE cycle starts, and a
    // new frame accepted in DONE cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            crc_reg   <= INIT;
            axiov_reg <= 1'b0;
            axiod_reg <= '0;
            busy_reg  <= 1'b0;
        end else if (clr) begin
            state_reg <= IDLE;
            crc_reg   <= INIT;
            axiov_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else if (axiiv) begin
            crc_reg <= crc_next;
            if (axiil) begin
                state_reg <= DONE;
                axiov_reg <= 1'b1;
                axiod_reg <= result_next;
                busy_reg  <= 1'b0;
            end else begin
                state_reg <= CALC;
                axiov_reg <= 1'b0;
                busy_reg  <= 1'b1;
            end
        end else begin
            if (state_reg == DONE) begin
                state_reg <= IDLE;
            end
            axiov_reg <= 1'b0;
        end
    end

`ifdef CRC_ENGINE_RESIDUE_CHECK_EN
    logic ok_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ok_reg <= 1'b0;
        end else if (clr) begin
            ok_reg <= 1'b0;
        end else if (axiiv && axiil) begin
            ok_reg <= (crc_next == RESIDUE);
        end
    end

    assign crc_ok = ok_reg;
`endif

    assign axiov = axiov_reg;
    assign axiod = axiod_reg;
    assign busy  = busy_reg;

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 Parameter WIDTH, default 8: CRC register width in bits, legal range 3..32.
REQ-002 Parameter DATA_W, default 8: input bits consumed per valid beat, legal range 1..16.
REQ-003 Parameter POLY, default 8'h1D: generator polynomial, normal form, x^WIDTH term implicit.
REQ-004 Parameter INIT, default all ones: register value loaded at frame start.
REQ-005 Parameter REFIN, default 1: 1 = axiid bit 0 processed first, 0 = bit DATA_W-1 processed first.
REQ-006 Parameter REFOUT, default 1: 1 = final register bit-reversed before XOROUT.
REQ-007 Parameter XOROUT, default 0: value XORed into the final result.
REQ-008 Parameter RESIDUE, default 0: expected raw register value after data plus appended CRC.
REQ-009 clk  in  1  sole clock; all state on rising edge.
REQ-010 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-011 axiiv  in  1  input beat valid.
REQ-012 axiid  in  DATA_W  input data beat.
REQ-013 axiil  in  1  last beat of frame; sampled only when axiiv=1.
REQ-014 clr  in  1  synchronous abort: discard current frame, return to IDLE.
REQ-015 axiov  out  1  result valid, single-cycle pulse.
REQ-016 axiod  out  WIDTH  final CRC of the most recent completed frame.
REQ-017 busy  out  1  high while a frame is in progress (state CALC).
REQ-018 crc_ok  out  1  residue match flag; present only per REQ-034.

Function
REQ-019 FSM states IDLE, CALC, DONE; one-hot or binary encoding at implementer's choice.
REQ-020 IDLE, axiiv=1: register <= step(INIT, axiid); next state CALC, or DONE if axiil=1.
REQ-021 CALC, axiiv=1: register <= step(register, axiid); next state DONE if axiil=1, else CALC.
REQ-022 Any state, axiiv=0: register and state unchanged, except DONE -> IDLE.
REQ-023 step() applies DATA_W serial LFSR shifts combinationally in one cycle; feedback = reg[WIDTH-1] XOR data bit; taps per POLY.
REQ-024 DONE lasts exactly one cycle: axiov=1; axiod = (REFOUT ? reverse(register) : register) XOR XOROUT.
REQ-025 Latency: axiov asserts on the cycle after the clock edge that accepted the axiil=1 beat.
REQ-026 axiod holds its value until the next DONE; it is not cleared by a new frame start.
REQ-027 DONE, axiiv=1: beat starts a new frame from INIT (as REQ-020); the pulse in flight is not lost.
REQ-028 Single-beat frame (axiiv=1, axiil=1 in IDLE) is legal: IDLE -> DONE -> IDLE.
REQ-029 clr=1 overrides axiiv: state <= IDLE, register <= INIT, no axiov pulse; axiod unchanged.
REQ-030 No input ready/backpressure: every axiiv=1 beat is accepted in its cycle.

Reset
REQ-031 rst=0 asynchronously forces state IDLE, register INIT, axiov 0, busy 0, axiod 0, crc_ok 0.
REQ-032 Reset mid-frame discards the partial frame; no axiov pulse follows reset release.
REQ-033 The first beat after rst deasserts is accepted as the first beat of a new frame.

Configuration
REQ-034 Macro CRC_ENGINE_RESIDUE_CHECK_EN defined: crc_ok port exists; crc_ok = (raw register == RESIDUE) during DONE, held until next DONE, 0 on reset/clr.
REQ-035 Macro undefined: crc_ok port and compare logic are absent; all other behaviour identical.

Verification
REQ-036 Defaults, DATA_W=8, bytes "123456789" (0x31..0x39), axiil on 0x39 -> one axiov pulse, axiod=8'h97, one cycle later.
REQ-037 WIDTH=32, POLY=32'h04C11DB7, INIT=32'hFFFFFFFF, REFIN=1, REFOUT=1, XOROUT=32'hFFFFFFFF, "123456789" -> axiod=32'hCBF43926.
REQ-038 WIDTH=16, POLY=16'h1021, INIT=16'hFFFF, REFIN=0, REFOUT=0, XOROUT=0, DATA_W=1, 72 serial bits MSB-first -> axiod=16'h29B1.
REQ-039 Defaults, "123456789" then axiil on 0x97 appended, macro defined -> crc_ok=1; corrupt one bit -> crc_ok=0.
REQ-040 Back-to-back frames ("123456789" twice, second starts in DONE cycle) -> two axiov pulses, both 8'h97; rst=0 or clr=1 at byte 4 of the first -> no pulse, the following full frame gives 8'h97.
